// File: rtl/countdown_timer.sv
// countdown_timer
// ---------------
// Countdown timer for the digital clock. A clamped H:M:S preset is loaded,
// then decremented by 1 ms on every Clock_1MSec edge while running. When the
// count reaches 0:00:00.000 the timer enters EXPIRED, raises Done_T, and pulses
// Alarm_T for exactly ALARM_MS cycles. The timer only advances while
// Control=1; with Control=0 every register holds.
//
// Ports:
//   Clock_1MSec  in   1 ms system clock
//   Reset        in   synchronous active-high reset (highest priority)
//   Control      in   1 = timer active, 0 = timer frozen
//   Load_T       in   load clamped preset (ignored in RUN)
//   Set_Hours/Set_Mins/Set_Secs  in  preset value
//   Start_T      in   start / resume
//   Stop_T       in   pause
//   Clear_T      in   clear to zero, go to IDLE
//   Hours_T/Mins_T/Secs_T/MSecs_T  out  remaining time
//   State_T      out  0=IDLE 1=RUN 2=PAUSE 3=EXPIRED
//   Done_T       out  high while EXPIRED
//   Alarm_T      out  high for ALARM_MS cycles from expiry
module countdown_timer #(
  parameter int unsigned ALARM_MS  = 3000,
  parameter int unsigned MAX_HOURS = 11
) (
  input  logic       Clock_1MSec,
  input  logic       Reset,
  input  logic       Control,
  input  logic       Load_T,
  input  logic [3:0] Set_Hours,
  input  logic [5:0] Set_Mins,
  input  logic [5:0] Set_Secs,
  input  logic       Start_T,
  input  logic       Stop_T,
  input  logic       Clear_T,
  output logic [3:0] Hours_T,
  output logic [5:0] Mins_T,
  output logic [5:0] Secs_T,
  output logic [9:0] MSecs_T,
  output logic [1:0] State_T,
  output logic       Done_T,
  output logic       Alarm_T
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSE   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  localparam logic [3:0]  MAX_H      = 4'(MAX_HOURS);
  localparam logic [15:0] ALARM_LOAD = 16'(ALARM_MS - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  hours_q, hours_d;
  logic [5:0]  mins_q,  mins_d;
  logic [5:0]  secs_q,  secs_d;
  logic [9:0]  msecs_q, msecs_d;
  logic        done_q,  done_d;
  logic        alarm_q, alarm_d;
  logic [15:0] acnt_q,  acnt_d;

  // Command decode, already resolved against Clear > Load > Stop > Start.
  logic time_zero;
  logic do_load;
  logic do_stop;
  logic do_start;
  logic do_tick;
  logic expire_now;

  assign time_zero = (hours_q == 4'd0) && (mins_q == 6'd0) &&
                     (secs_q == 6'd0) && (msecs_q == 10'd0);
  assign do_load   = !Clear_T && Load_T && (state_q != ST_RUN);
  assign do_stop   = !Clear_T && Stop_T && (state_q == ST_RUN);
  assign do_start  = !Clear_T && !do_load && !do_stop && Start_T &&
                     (((state_q == ST_IDLE) && !time_zero) || (state_q == ST_PAUSE));
  // Load is never accepted in RUN, and Start never acts in RUN, so only Stop
  // and Clear can pre-empt the decrement.
  assign do_tick   = !Clear_T && !do_stop && (state_q == ST_RUN);
  // Last millisecond (or a degenerate zero count) ends the run on this edge.
  assign expire_now = do_tick && (hours_q == 4'd0) && (mins_q == 6'd0) &&
                      (secs_q == 6'd0) && (msecs_q <= 10'd1);

  // State and datapath registers: sync reset, then hold whenever Control=0.
  always_ff @(posedge Clock_1MSec) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      hours_q <= 4'd0;
      mins_q  <= 6'd0;
      secs_q  <= 6'd0;
      msecs_q <= 10'd0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
      acnt_q  <= 16'd0;
    end else if (Control) begin
      state_q <= state_d;
      hours_q <= hours_d;
      mins_q  <= mins_d;
      secs_q  <= secs_d;
      msecs_q <= msecs_d;
      done_q  <= done_d;
      alarm_q <= alarm_d;
      acnt_q  <= acnt_d;
    end else begin
      state_q <= state_q;
      hours_q <= hours_q;
      mins_q  <= mins_q;
      secs_q  <= secs_q;
      msecs_q <= msecs_q;
      done_q  <= done_q;
      alarm_q <= alarm_q;
      acnt_q  <= acnt_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (Clear_T || do_load) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = do_start ? ST_RUN : ST_IDLE;
        ST_RUN: begin
          if (do_stop) begin
            state_d = ST_PAUSE;
          end else if (expire_now) begin
            state_d = ST_EXPIRED;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE:   state_d = do_start ? ST_RUN : ST_PAUSE;
        ST_EXPIRED: state_d = ST_EXPIRED;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Time, flag and alarm-counter next values.
  always_comb begin
    hours_d = hours_q;
    mins_d  = mins_q;
    secs_d  = secs_q;
    msecs_d = msecs_q;
    done_d  = done_q;
    alarm_d = alarm_q;
    acnt_d  = acnt_q;
    if (Clear_T) begin
      hours_d = 4'd0;
      mins_d  = 6'd0;
      secs_d  = 6'd0;
      msecs_d = 10'd0;
      done_d  = 1'b0;
      alarm_d = 1'b0;
      acnt_d  = 16'd0;
    end else if (do_load) begin
      hours_d = (Set_Hours > MAX_H)  ? MAX_H : Set_Hours;
      mins_d  = (Set_Mins > 6'd59)   ? 6'd59 : Set_Mins;
      secs_d  = (Set_Secs > 6'd59)   ? 6'd59 : Set_Secs;
      msecs_d = 10'd0;
      done_d  = 1'b0;
      alarm_d = 1'b0;
      acnt_d  = 16'd0;
    end else if (expire_now) begin
      hours_d = 4'd0;
      mins_d  = 6'd0;
      secs_d  = 6'd0;
      msecs_d = 10'd0;
      done_d  = 1'b1;
      alarm_d = 1'b1;
      acnt_d  = ALARM_LOAD;
    end else if (do_tick) begin
      // Borrow chain ms -> s -> min -> h; hours cannot underflow because
      // expiry is detected one millisecond earlier.
      if (msecs_q != 10'd0) begin
        msecs_d = msecs_q - 10'd1;
      end else begin
        msecs_d = 10'd999;
        if (secs_q != 6'd0) begin
          secs_d = secs_q - 6'd1;
        end else begin
          secs_d = 6'd59;
          if (mins_q != 6'd0) begin
            mins_d = mins_q - 6'd1;
          end else begin
            mins_d  = 6'd59;
            hours_d = hours_q - 4'd1;
          end
        end
      end
    end else if ((state_q == ST_EXPIRED) && alarm_q) begin
      // Alarm drops on the edge that sees the counter at zero.
      if (acnt_q == 16'd0) begin
        alarm_d = 1'b0;
      end else begin
        acnt_d = acnt_q - 16'd1;
      end
    end else begin
      acnt_d = acnt_q;
    end
  end

  assign Hours_T = hours_q;
  assign Mins_T  = mins_q;
  assign Secs_T  = secs_q;
  assign MSecs_T = msecs_q;
  assign State_T = state_q;
  assign Done_T  = done_q;
  assign Alarm_T = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed testbench for countdown_timer (default ALARM_MS=3000, MAX_HOURS=11).
// Observed outputs are packed as {H,M,S,MS,State,Done,Alarm} and compared
// against hand-computed vectors.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       Reset, Control, Load_T, Start_T, Stop_T, Clear_T;
  logic [3:0] Set_Hours;
  logic [5:0] Set_Mins, Set_Secs;
  logic [3:0] Hours_T;
  logic [5:0] Mins_T, Secs_T;
  logic [9:0] MSecs_T;
  logic [1:0] State_T;
  logic       Done_T, Alarm_T;

  int total = 0;
  int bad   = 0;

  countdown_timer dut (
    .Clock_1MSec(clk),
    .Reset(Reset),
    .Control(Control),
    .Load_T(Load_T),
    .Set_Hours(Set_Hours),
    .Set_Mins(Set_Mins),
    .Set_Secs(Set_Secs),
    .Start_T(Start_T),
    .Stop_T(Stop_T),
    .Clear_T(Clear_T),
    .Hours_T(Hours_T),
    .Mins_T(Mins_T),
    .Secs_T(Secs_T),
    .MSecs_T(MSecs_T),
    .State_T(State_T),
    .Done_T(Done_T),
    .Alarm_T(Alarm_T)
  );

  always #5 clk = ~clk;

  logic [29:0] obs;
  assign obs = {Hours_T, Mins_T, Secs_T, MSecs_T, State_T, Done_T, Alarm_T};

  function automatic logic [29:0] pk(input int h, input int m, input int s, input int ms,
                                     input int st, input int d, input int a);
    return {4'(h), 6'(m), 6'(s), 10'(ms), 2'(st), 1'(d), 1'(a)};
  endfunction

  // Advance n active edges, then sample 1 time unit after the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_preset(input int h, input int m, input int s);
    Set_Hours = 4'(h); Set_Mins = 6'(m); Set_Secs = 6'(s);
    Load_T = 1'b1; step(1); Load_T = 1'b0;
  endtask

  task automatic do_clear();
    Clear_T = 1'b1; step(1); Clear_T = 1'b0;
  endtask

  task automatic test_reset();
    load_preset(0, 0, 5);
    Start_T = 1'b1; step(1); Start_T = 1'b0;
    step(3);
    total++;
    if (obs !== pk(0, 0, 4, 997, 1, 0, 0)) begin
      bad++; $display("FAIL pre_reset_run: got %h exp %h", obs, pk(0, 0, 4, 997, 1, 0, 0));
    end
    Reset = 1'b1; Control = 1'b0; Load_T = 1'b1; Start_T = 1'b1;
    step(1);
    Reset = 1'b0; Control = 1'b1; Load_T = 1'b0; Start_T = 1'b0;
    total++;
    if (obs !== pk(0, 0, 0, 0, 0, 0, 0)) begin
      bad++; $display("FAIL reset_state: got %h exp %h", obs, pk(0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_expiry();
    load_preset(0, 0, 1);
    total++;
    if (obs !== pk(0, 0, 1, 0, 0, 0, 0)) begin
      bad++; $display("FAIL exp_load: got %h exp %h", obs, pk(0, 0, 1, 0, 0, 0, 0));
    end
    Start_T = 1'b1; step(1); Start_T = 1'b0;
    total++;
    if (obs !== pk(0, 0, 1, 0, 1, 0, 0)) begin
      bad++; $display("FAIL exp_start_no_dec: got %h exp %h", obs, pk(0, 0, 1, 0, 1, 0, 0));
    end
    step(1);
    total++;
    if (obs !== pk(0, 0, 0, 999, 1, 0, 0)) begin
      bad++; $display("FAIL exp_first_dec: got %h exp %h", obs, pk(0, 0, 0, 999, 1, 0, 0));
    end
    step(998);
    total++;
    if (obs !== pk(0, 0, 0, 1, 1, 0, 0)) begin
      bad++; $display("FAIL exp_last_ms: got %h exp %h", obs, pk(0, 0, 0, 1, 1, 0, 0));
    end
    step(1);
    total++;
    if (obs !== pk(0, 0, 0, 0, 3, 1, 1)) begin
      bad++; $display("FAIL exp_expired: got %h exp %h", obs, pk(0, 0, 0, 0, 3, 1, 1));
    end
    Start_T = 1'b1; step(1); Start_T = 1'b0;
    total++;
    if (obs !== pk(0, 0, 0, 0, 3, 1, 1)) begin
      bad++; $display("FAIL exp_start_ignored: got %h exp %h", obs, pk(0, 0, 0, 0, 3, 1, 1));
    end
    step(2998);
    total++;
    if (obs !== pk(0, 0, 0, 0, 3, 1, 1)) begin
      bad++; $display("FAIL alarm_last_cycle: got %h exp %h", obs, pk(0, 0, 0, 0, 3, 1, 1));
    end
    step(1);
    total++;
    if (obs !== pk(0, 0, 0, 0, 3, 1, 0)) begin
      bad++; $display("FAIL alarm_fall: got %h exp %h", obs, pk(0, 0, 0, 0, 3, 1, 0));
    end
  endtask

  task automatic test_borrow();
    do_clear();
    load_preset(1, 0, 0);
    Start_T = 1'b1; step(1); Start_T = 1'b0;
    step(1);
    total++;
    if (obs !== pk(0, 59, 59, 999, 1, 0, 0)) begin
      bad++; $display("FAIL borrow_chain: got %h exp %h", obs, pk(0, 59, 59, 999, 1, 0, 0));
    end
  endtask

  task automatic test_pause();
    do_clear();
    total++;
    if (obs !== pk(0, 0, 0, 0, 0, 0, 0)) begin
      bad++; $display("FAIL clear_from_run: got %h exp %h", obs, pk(0, 0, 0, 0, 0, 0, 0));
    end
    load_preset(0, 0, 5);
    Start_T = 1'b1; step(1); Start_T = 1'b0;
    step(2000);
    total++;
    if (obs !== pk(0, 0, 3, 0, 1, 0, 0)) begin
      bad++; $display("FAIL pause_run2000: got %h exp %h", obs, pk(0, 0, 3, 0, 1, 0, 0));
    end
    Stop_T = 1'b1; step(1); Stop_T = 1'b0;
    total++;
    if (obs !== pk(0, 0, 3, 0, 2, 0, 0)) begin
      bad++; $display("FAIL pause_enter: got %h exp %h", obs, pk(0, 0, 3, 0, 2, 0, 0));
    end
    step(500);
    total++;
    if (obs !== pk(0, 0, 3, 0, 2, 0, 0)) begin
      bad++; $display("FAIL pause_hold: got %h exp %h", obs, pk(0, 0, 3, 0, 2, 0, 0));
    end
    Start_T = 1'b1; step(1); Start_T = 1'b0;
    total++;
    if (obs !== pk(0, 0, 3, 0, 1, 0, 0)) begin
      bad++; $display("FAIL pause_resume: got %h exp %h", obs, pk(0, 0, 3, 0, 1, 0, 0));
    end
    step(2999);
    total++;
    if (obs !== pk(0, 0, 0, 1, 1, 0, 0)) begin
      bad++; $display("FAIL resume_2999: got %h exp %h", obs, pk(0, 0, 0, 1, 1, 0, 0));
    end
    step(1);
    total++;
    if (obs !== pk(0, 0, 0, 0, 3, 1, 1)) begin
      bad++; $display("FAIL resume_expiry: got %h exp %h", obs, pk(0, 0, 0, 0, 3, 1, 1));
    end
  endtask

  task automatic test_clamp_and_ignore();
    load_preset(15, 63, 60);
    total++;
    if (obs !== pk(11, 59, 59, 0, 0, 0, 0)) begin
      bad++; $display("FAIL load_clamp: got %h exp %h", obs, pk(11, 59, 59, 0, 0, 0, 0));
    end
    do_clear();
    load_preset(0, 0, 0);
    Start_T = 1'b1; step(1); Start_T = 1'b0;
    total++;
    if (obs !== pk(0, 0, 0, 0, 0, 0, 0)) begin
      bad++; $display("FAIL start_zero_ignored: got %h exp %h", obs, pk(0, 0, 0, 0, 0, 0, 0));
    end
    load_preset(0, 0, 10);
    Start_T = 1'b1; step(1); Start_T = 1'b0;
    Set_Hours = 4'd2; Set_Mins = 6'd0; Set_Secs = 6'd0;
    Load_T = 1'b1; step(1); Load_T = 1'b0;
    total++;
    if (obs !== pk(0, 0, 9, 999, 1, 0, 0)) begin
      bad++; $display("FAIL load_in_run_ignored: got %h exp %h", obs, pk(0, 0, 9, 999, 1, 0, 0));
    end
  endtask

  task automatic test_control();
    Control = 1'b0; Stop_T = 1'b1; Clear_T = 1'b1;
    step(100);
    total++;
    if (obs !== pk(0, 0, 9, 999, 1, 0, 0)) begin
      bad++; $display("FAIL control_freeze: got %h exp %h", obs, pk(0, 0, 9, 999, 1, 0, 0));
    end
    Control = 1'b1; Stop_T = 1'b0; Clear_T = 1'b0;
    step(1);
    total++;
    if (obs !== pk(0, 0, 9, 998, 1, 0, 0)) begin
      bad++; $display("FAIL control_resume: got %h exp %h", obs, pk(0, 0, 9, 998, 1, 0, 0));
    end
    Start_T = 1'b1; Stop_T = 1'b1; step(1); Start_T = 1'b0; Stop_T = 1'b0;
    total++;
    if (obs !== pk(0, 0, 9, 998, 2, 0, 0)) begin
      bad++; $display("FAIL stop_start_together: got %h exp %h", obs, pk(0, 0, 9, 998, 2, 0, 0));
    end
    Clear_T = 1'b1; Start_T = 1'b1; step(1); Clear_T = 1'b0; Start_T = 1'b0;
    total++;
    if (obs !== pk(0, 0, 0, 0, 0, 0, 0)) begin
      bad++; $display("FAIL clear_with_start: got %h exp %h", obs, pk(0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  initial begin
    Reset = 1'b1; Control = 1'b1; Load_T = 1'b0; Start_T = 1'b0; Stop_T = 1'b0;
    Clear_T = 1'b0; Set_Hours = 4'd0; Set_Mins = 6'd0; Set_Secs = 6'd0;
    step(2);
    Reset = 1'b0;
    test_reset();
    test_expiry();
    test_borrow();
    test_pause();
    test_clamp_and_ignore();
    test_control();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Countdown timer for the digital clock; the counting-down counterpart of the stopwatch.
- Loads an H:M:S preset, decrements once per Clock_1MSec edge to 0:00:00.000, then raises a completion flag and a timed alarm pulse.
- Shares the clock's mode-select input. It counts only while Control=1, the inverse of the stopwatch, which is active at Control=0.
- Outputs feed the same display mux as the stopwatch time fields.

Parameters:
ALARM_MS, 3000, number of Clock_1MSec cycles Alarm_T stays high after expiry (1..65535)
MAX_HOURS, 11, maximum loadable hour value; larger Set_Hours values clamp to it

Ports:
Clock_1MSec  input  1  system clock, one edge = 1 ms
Reset  input  1  synchronous, active-high reset
Control  input  1  mode select; 1 = timer active, 0 = timer frozen
Load_T  input  1  load preset (level sampled each edge)
Set_Hours  input  4  preset hours
Set_Mins  input  6  preset minutes
Set_Secs  input  6  preset seconds
Start_T  input  1  start/resume
Stop_T  input  1  pause
Clear_T  input  1  clear to zero, return to IDLE
Hours_T  output  4  remaining hours
Mins_T  output  6  remaining minutes (0..59)
Secs_T  output  6  remaining seconds (0..59)
MSecs_T  output  10  remaining milliseconds (0..999)
State_T  output  2  0=IDLE 1=RUN 2=PAUSE 3=EXPIRED
Done_T  output  1  high while in EXPIRED
Alarm_T  output  1  high for ALARM_MS cycles starting at expiry

Behaviour:
- Reset (sync, active-high, highest priority) sets all time outputs to 0, State_T to IDLE, Done_T to 0 and Alarm_T to 0. The internal alarm counter is also cleared. Reset applies regardless of Control.
- Control=0: all registers hold, including the alarm counter, and every other input is ignored.
- With Control=1, inputs are evaluated in this priority order: Clear_T > Load_T > Stop_T > Start_T.
- Clear_T (any state): time to 0, go to IDLE, Done_T=0, Alarm_T=0, alarm counter=0.
- Load_T (accepted in IDLE, PAUSE and EXPIRED; ignored in RUN):
  - Hours_T = min(Set_Hours, MAX_HOURS); Mins_T = min(Set_Mins, 59); Secs_T = min(Set_Secs, 59); MSecs_T = 0.
  - Go to IDLE; Done_T and Alarm_T drop to 0.
- Start_T:
  - IDLE with nonzero time: go to RUN. No decrement occurs on the accepting edge.
  - IDLE with zero time: ignored.
  - PAUSE: go to RUN.
  - RUN and EXPIRED: ignored.
- Stop_T:
  - RUN: go to PAUSE; time holds at its current value.
  - All other states: ignored.
  - Stop_T and Start_T asserted together in RUN: go to PAUSE.
- RUN decrement, once per edge, applied when no higher-priority input acts:
  - MSecs_T>0: MSecs_T-1.
  - Otherwise MSecs_T=999 and borrow into seconds: Secs_T>0 gives Secs_T-1; otherwise Secs_T=59 and borrow into minutes.
  - Minutes borrow the same way (Mins_T=59 on underflow) into hours; hours borrow is Hours_T-1.
  - Hours never underflow, because expiry occurs first.
- Expiry: the edge on which RUN decrements 0:00:00.001 to 0:00:00.000 also sets State_T to EXPIRED, Done_T to 1 and Alarm_T to 1, and loads the alarm counter with ALARM_MS-1.
- EXPIRED:
  - Time holds at 0.
  - Alarm counter decrements each edge; Alarm_T falls on the edge where the counter is 0. Alarm_T is therefore high for exactly ALARM_MS cycles.
  - Done_T stays high until Clear_T or Load_T.
- Total latency: Start accepted at edge N on a preset of T ms gives expiry at edge N+T.
- Outputs are registered with no combinational paths from inputs.

Test Plan:
- Reset=1 for 1 edge with arbitrary prior state -> all outputs 0 and State_T=0 on that edge.
- Load 0:00:01, Start at edge N -> MSecs_T=999 at N+1, Secs_T=0; at N+1000 outputs 0:00:00.000, State_T=3, Done_T=1, Alarm_T=1. Alarm_T falls after 3000 cycles; Done_T stays 1.
- Load 1:00:00, run 1 edge -> time reads 0:59:59.999 (full borrow chain).
- Load 0:00:05, run 2000 edges, Stop_T for 1 edge, wait 500 edges, then Start_T -> time frozen at 0:00:03.000 (±1 ms per the acceptance edge) during the pause; expiry occurs exactly 3000 edges after resume.
- Set_Hours=15, Set_Mins=63, Set_Secs=60 with Load_T -> 11:59:59.000. Start_T on a zero preset -> State_T stays 0. Load_T during RUN -> ignored.
- In RUN, drop Control to 0 for 100 edges -> no change to any output; counting resumes when Control returns to 1. Clear_T with Start_T together -> zeros and IDLE.
